// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register.
// It captures the ALU result and the control bits that travel with it, and
// resolves conditional branches from the Zero flag.
// The stage holds up to two entries (main plus skid), so in_ready comes
// straight from a flop and never waits on out_ready.
// Optional feature: define EX_MEM_BNE_EN to add the is_bne input, which
// enables branch-if-not-equal resolution.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_W-1:0]     store_data,
  input  logic                  is_branch,
`ifdef EX_MEM_BNE_EN
  input  logic                  is_bne,
`endif
  input  logic [DATA_W-1:0]     branch_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [DATA_W-1:0]     out_store_data,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target
);

  // One buffered instruction as the memory stage sees it.
  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     store_data;
  } entry_t;

  // EMPTY: no entry held, ONE: main entry only, FULL: main and skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q;
  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  logic              branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;

  logic   accept;
  logic   pop;
  logic   branch_cond;
  logic   load_main_in;
  logic   load_main_skid;
  logic   load_skid;
  entry_t in_entry;

  assign in_entry.result     = alu_result;
  assign in_entry.rd         = rd_addr;
  assign in_entry.reg_write  = reg_write;
  assign in_entry.mem_read   = mem_read;
  assign in_entry.mem_write  = mem_write;
  assign in_entry.store_data = store_data;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

`ifdef EX_MEM_BNE_EN
  // BEQ takes precedence: when is_branch and is_bne are both set, only the Zero=1 case branches.
  assign branch_cond = is_branch ? alu_zero : (is_bne & ~alu_zero);
`else
  assign branch_cond = is_branch & alu_zero;
`endif

  // State register plus the registered ready, which tracks the next state so it is never combinational.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Next-state logic: flush empties the buffer, otherwise accept/pop move the occupancy.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) state_d = ONE;
        end
        ONE: begin
          if (accept && !pop)      state_d = FULL;
          else if (!accept && pop) state_d = EMPTY;
        end
        FULL: begin
          if (pop) state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM outputs: the valid flag and which storage slot gets loaded this cycle.
  always_comb begin
    out_valid      = (state_q != EMPTY);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: load_main_in = accept;
        ONE: begin
          load_main_in = accept & pop;
          load_skid    = accept & ~pop;
        end
        FULL:    load_main_skid = pop;
        default: ;
      endcase
    end
  end

  // Entry datapath: main takes the new entry or the skid entry; skid only ever takes a new entry.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main_in)        main_d = in_entry;
    else if (load_main_skid) main_d = skid_q;
    if (load_skid)           skid_d = in_entry;
  end

  // Entry storage; reset clears the data so the out_* ports read zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Branch resolution at accept time: a taken branch pulses for one cycle and latches its target.
  always_comb begin
    branch_taken_d  = accept & ~flush & branch_cond;
    branch_target_d = branch_taken_d ? branch_pc : branch_target_q;
  end

  // Branch report registers; the target holds its last value between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_alu_result = main_q.result;
  assign out_rd_addr    = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_store_data = main_q.store_data;
  assign branch_taken   = branch_taken_q;
  assign branch_target  = branch_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage.
// The reference model is a plain FIFO queue of at most two entries plus the
// expected branch pulse and target.
module tb_ex_mem_stage;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef EX_MEM_BNE_EN
   localparam bit BNE_ON = 1'b1;
`else
   localparam bit BNE_ON = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] res;
      logic [AW-1:0] rd;
      logic          rw;
      logic          mr;
      logic          mw;
      logic [DW-1:0] sd;
   } entry_t;

   typedef struct {
      bit            v;
      logic [DW-1:0] res;
      logic [AW-1:0] rd;
      bit            rw;
      bit            mr;
      bit            mw;
      logic [DW-1:0] sd;
      bit            br;
      bit            z;
      bit            bne;
      logic [DW-1:0] pc;
      bit            fl;
      bit            ordy;
   } stim_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          inValid = 1'b0;
   logic          inReady;
   logic [DW-1:0] aluResult = '0;
   logic          aluZero = 1'b0;
   logic [AW-1:0] rdAddr = '0;
   logic          regWrite = 1'b0;
   logic          memRead = 1'b0;
   logic          memWrite = 1'b0;
   logic [DW-1:0] storeData = '0;
   logic          isBranch = 1'b0;
   logic          isBne = 1'b0;
   logic [DW-1:0] branchPc = '0;
   logic          flush = 1'b0;
   logic          outValid;
   logic          outReady = 1'b0;
   logic [DW-1:0] outAluResult;
   logic [AW-1:0] outRdAddr;
   logic          outRegWrite;
   logic          outMemRead;
   logic          outMemWrite;
   logic [DW-1:0] outStoreData;
   logic          branchTaken;
   logic [DW-1:0] branchTarget;

   entry_t        expQ[$];
   bit            expTaken = 1'b0;
   logic [DW-1:0] expTarget = '0;
   bit            checkEn = 1'b0;
   int            total = 0;
   int            bad = 0;

   ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(inValid),
      .in_ready(inReady),
      .alu_result(aluResult),
      .alu_zero(aluZero),
      .rd_addr(rdAddr),
      .reg_write(regWrite),
      .mem_read(memRead),
      .mem_write(memWrite),
      .store_data(storeData),
      .is_branch(isBranch),
`ifdef EX_MEM_BNE_EN
      .is_bne(isBne),
`endif
      .branch_pc(branchPc),
      .flush(flush),
      .out_valid(outValid),
      .out_ready(outReady),
      .out_alu_result(outAluResult),
      .out_rd_addr(outRdAddr),
      .out_reg_write(outRegWrite),
      .out_mem_read(outMemRead),
      .out_mem_write(outMemWrite),
      .out_store_data(outStoreData),
      .branch_taken(branchTaken),
      .branch_target(branchTarget)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Branch rule: BEQ on Zero=1; BNE (when built in) on Zero=0, with BEQ winning if both flags are set.
   function automatic bit modelTaken();
      if (isBranch) return aluZero;
      return BNE_ON && isBne && !aluZero;
   endfunction

   // Compares the DUT outputs against the model and retires the head entry on a memory-side pop.
   task automatic checkOutput();
      entry_t head;
      checkVal("out_valid", 32'(outValid), 32'(expQ.size() != 0));
      checkVal("in_ready", 32'(inReady), 32'(expQ.size() < 2));
      checkVal("branch_taken", 32'(branchTaken), 32'(expTaken));
      checkVal("branch_target", branchTarget, expTarget);
      if (outValid && expQ.size() > 0) begin
         head = expQ[0];
         checkVal("out_alu_result", outAluResult, head.res);
         checkVal("out_rd_addr", 32'(outRdAddr), 32'(head.rd));
         checkVal("out_reg_write", 32'(outRegWrite), 32'(head.rw));
         checkVal("out_mem_read", 32'(outMemRead), 32'(head.mr));
         checkVal("out_mem_write", 32'(outMemWrite), 32'(head.mw));
         checkVal("out_store_data", outStoreData, head.sd);
         if (outReady) void'(expQ.pop_front());
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) checkOutput();
   end

   // Advances one clock and updates the model with what was offered in that cycle.
   task automatic stepCycle(output bit accepted);
      bit            acc;
      bit            tk;
      bit            rs;
      bit            fl;
      logic [DW-1:0] pc;
      entry_t        e;
      acc = inValid && (expQ.size() < 2);
      tk = acc && !flush && modelTaken();
      rs = reset;
      fl = flush;
      pc = branchPc;
      e.res = aluResult;
      e.rd = rdAddr;
      e.rw = regWrite;
      e.mr = memRead;
      e.mw = memWrite;
      e.sd = storeData;
      @(posedge clk);
      #1;
      if (rs) begin
         expQ.delete();
         expTaken = 1'b0;
         expTarget = '0;
      end else begin
         expTaken = tk;
         if (tk) expTarget = pc;
         if (fl) expQ.delete();
         else if (acc) expQ.push_back(e);
      end
      accepted = acc && !rs && !fl;
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s.v = 1'b0; s.res = '0; s.rd = '0; s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0;
      s.sd = '0; s.br = 1'b0; s.z = 1'b0; s.bne = 1'b0; s.pc = '0; s.fl = 1'b0;
      s.ordy = 1'b1;
      return s;
   endfunction

   // Drives one cycle of execute-side and memory-side inputs, then clocks it through the model.
   task automatic applyStimulus(input stim_t s, output bit accepted);
      inValid = s.v;
      aluResult = s.res;
      rdAddr = s.rd;
      regWrite = s.rw;
      memRead = s.mr;
      memWrite = s.mw;
      storeData = s.sd;
      isBranch = s.br;
      aluZero = s.z;
      isBne = s.bne;
      branchPc = s.pc;
      flush = s.fl;
      outReady = s.ordy;
      stepCycle(accepted);
   endtask

   // Keeps offering an entry until the model says it was taken, within a small cycle budget.
   task automatic offerUntilAccepted(input stim_t s);
      bit acc;
      acc = 1'b0;
      for (int n = 0; n < 8 && !acc; n++) applyStimulus(s, acc);
      checkVal("offer_accepted", 32'(acc), 32'd1);
   endtask

   task automatic checkResetValues();
      checkVal("rst_out_alu_result", outAluResult, '0);
      checkVal("rst_out_rd_addr", 32'(outRdAddr), 32'd0);
      checkVal("rst_out_reg_write", 32'(outRegWrite), 32'd0);
      checkVal("rst_out_mem_read", 32'(outMemRead), 32'd0);
      checkVal("rst_out_mem_write", 32'(outMemWrite), 32'd0);
      checkVal("rst_out_store_data", outStoreData, '0);
      checkVal("rst_out_valid", 32'(outValid), 32'd0);
      checkVal("rst_in_ready", 32'(inReady), 32'd1);
      checkVal("rst_branch_taken", 32'(branchTaken), 32'd0);
      checkVal("rst_branch_target", branchTarget, '0);
   endtask

   // Main sequence: reset, directed cases, then randomized traffic.
   initial begin
      stim_t s;
      bit    acc;

      reset = 1'b1;
      applyStimulus(idleStim(), acc);
      applyStimulus(idleStim(), acc);
      reset = 1'b0;
      checkEn = 1'b1;
      checkResetValues();

      s = idleStim();
      s.v = 1'b1; s.res = 32'd16; s.rd = 5'd3; s.rw = 1'b1;
      applyStimulus(s, acc);
      checkVal("single_valid", 32'(outValid), 32'd1);
      checkVal("single_result", outAluResult, 32'd16);
      checkVal("single_rd", 32'(outRdAddr), 32'd3);
      applyStimulus(idleStim(), acc);
      checkVal("single_drained", 32'(outValid), 32'd0);

      s = idleStim();
      s.v = 1'b1; s.ordy = 1'b0; s.rw = 1'b1;
      s.res = 32'd6; s.rd = 5'd6; applyStimulus(s, acc);
      s.res = 32'd7; s.rd = 5'd7; applyStimulus(s, acc);
      checkVal("bp_in_ready_low", 32'(inReady), 32'd0);
      s.res = 32'd8; s.rd = 5'd8; applyStimulus(s, acc);
      checkVal("bp_third_refused", 32'(acc), 32'd0);
      checkVal("bp_head_stable", outAluResult, 32'd6);
      s.ordy = 1'b1;
      offerUntilAccepted(s);
      for (int i = 0; i < 3; i++) applyStimulus(idleStim(), acc);
      checkVal("bp_drained", 32'(outValid), 32'd0);

      s = idleStim();
      s.v = 1'b1; s.br = 1'b1; s.z = 1'b1; s.pc = 32'h0000_0040;
      applyStimulus(s, acc);
      checkVal("beq_taken", 32'(branchTaken), 32'd1);
      checkVal("beq_target", branchTarget, 32'h40);
      applyStimulus(idleStim(), acc);
      checkVal("beq_one_cycle", 32'(branchTaken), 32'd0);
      s.z = 1'b0; s.pc = 32'h0000_0099;
      applyStimulus(s, acc);
      checkVal("beq_not_taken", 32'(branchTaken), 32'd0);
      checkVal("beq_target_held", branchTarget, 32'h40);
      applyStimulus(idleStim(), acc);

`ifdef EX_MEM_BNE_EN
      s = idleStim();
      s.v = 1'b1; s.bne = 1'b1; s.z = 1'b0; s.pc = 32'h0000_0080;
      applyStimulus(s, acc);
      checkVal("bne_taken", 32'(branchTaken), 32'd1);
      checkVal("bne_target", branchTarget, 32'h80);
      s.z = 1'b1; s.pc = 32'h0000_0084;
      applyStimulus(s, acc);
      checkVal("bne_not_taken", 32'(branchTaken), 32'd0);
      s.br = 1'b1; s.z = 1'b0; s.pc = 32'h0000_0088;
      applyStimulus(s, acc);
      checkVal("bne_beq_priority", 32'(branchTaken), 32'd0);
      applyStimulus(idleStim(), acc);
`endif

      s = idleStim();
      s.v = 1'b1; s.ordy = 1'b0;
      s.res = 32'h11; applyStimulus(s, acc);
      s.res = 32'h22; applyStimulus(s, acc);
      s.res = 32'h33; s.br = 1'b1; s.z = 1'b1; s.pc = 32'h44; s.fl = 1'b1;
      applyStimulus(s, acc);
      checkVal("flush_out_valid", 32'(outValid), 32'd0);
      checkVal("flush_in_ready", 32'(inReady), 32'd1);
      checkVal("flush_no_branch", 32'(branchTaken), 32'd0);

      s = idleStim();
      s.v = 1'b1; s.ordy = 1'b0; s.rw = 1'b1; s.mw = 1'b1; s.sd = 32'hDEAD_BEEF;
      s.res = 32'h55; applyStimulus(s, acc);
      s.res = 32'h66; applyStimulus(s, acc);
      reset = 1'b1;
      s.fl = 1'b1; s.res = 32'h67;
      applyStimulus(s, acc);
      reset = 1'b0;
      checkResetValues();
      s = idleStim();
      s.v = 1'b1; s.ordy = 1'b0; s.res = 32'h77; s.rd = 5'd9; s.mr = 1'b1;
      applyStimulus(s, acc);
      checkVal("post_rst_valid", 32'(outValid), 32'd1);
      checkVal("post_rst_result", outAluResult, 32'h77);
      applyStimulus(idleStim(), acc);

      for (int i = 0; i < 800; i++) begin
         s.v = ($urandom_range(0, 9) < 7);
         s.res = $urandom;
         s.rd = 5'($urandom);
         s.rw = 1'($urandom);
         s.mr = 1'($urandom);
         s.mw = 1'($urandom);
         s.sd = $urandom;
         s.br = ($urandom_range(0, 3) == 0);
         s.z = 1'($urandom);
         s.bne = 1'($urandom);
         s.pc = $urandom;
         s.fl = ($urandom_range(0, 24) == 0);
         s.ordy = ($urandom_range(0, 9) < 6);
         reset = ($urandom_range(0, 199) == 0);
         applyStimulus(s, acc);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(idleStim(), acc);
      checkVal("final_drained", 32'(outValid), 32'd0);

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the 32-bit execute ALU. Captures the ALU result, Zero flag and carried-along control/data for the memory stage.
- Resolves conditional branches from Zero and reports taken branches to fetch.
- Two-entry skid buffer with valid/ready on both sides, so memory-side back-pressure never forces a combinational ready path to the ALU.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target
- REG_ADDR_W, 5, width of destination register index

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  stage can accept; registered, never depends combinationally on out_ready
- alu_result  input  DATA_W  ALU Output
- alu_zero  input  1  ALU Zero flag; meaningful only for subtract (opcode 2'b10)
- rd_addr  input  REG_ADDR_W  destination register
- reg_write  input  1  write-back enable
- mem_read  input  1  load
- mem_write  input  1  store
- store_data  input  DATA_W  store operand
- is_branch  input  1  conditional branch; upstream drives ALU subtract for it
- branch_pc  input  DATA_W  precomputed branch target
- flush  input  1  discard all held and incoming instructions
- out_valid  output  1  memory stage entry valid
- out_ready  input  1  memory stage accepts
- out_alu_result  output  DATA_W  head entry result
- out_rd_addr  output  REG_ADDR_W  head entry destination
- out_reg_write  output  1  head entry write-back enable
- out_mem_read  output  1  head entry load
- out_mem_write  output  1  head entry store
- out_store_data  output  DATA_W  head entry store data
- branch_taken  output  1  one-cycle pulse, branch resolved taken
- branch_target  output  DATA_W  target, valid while branch_taken=1

Behaviour:
- Storage: main entry (drives the out_* ports) and skid entry. State is encoded as EMPTY (none valid), ONE (main only) or FULL (main+skid).
- Handshake terms: accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != FULL), registered.
- out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: accept -> ONE, entry loads into main.
  - ONE: accept & pop -> ONE, main replaced by the new entry. accept only -> FULL, new entry goes to skid. pop only -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, skid moves to main. No pop -> hold. in_valid is ignored.
- Order is strictly FIFO. An entry appears on out_* the cycle after it is accepted (latency 1), and holds stable while out_valid=1 and out_ready=0.
- Branch resolution happens at accept time.
  - If is_branch=1 and alu_zero=1, branch_taken=1 and branch_target=branch_pc on the next cycle, for exactly one cycle.
  - Otherwise branch_taken=0 and branch_target holds its last value.
- A branch entry still flows down the pipe with whatever control bits it was given.
- Flush (when reset=0): next cycle the state is EMPTY, out_valid=0 and in_ready=1. An entry offered in the flush cycle is dropped, and no branch_taken pulse is raised for it. A pop in the flush cycle still counts as completed at the memory side.
- Reset has priority over flush. On reset, next cycle:
  - state EMPTY, in_ready=1, out_valid=0, branch_taken=0
  - branch_target=0
  - all out_* data/control = 0
- Reset asserted mid-operation discards both entries.
- Data fields pass through unmodified at full DATA_W. No arithmetic other than the Zero test.

Optional Feature:
- Macro EX_MEM_BNE_EN.
- When defined: adds input is_bne (1 bit). An accepted entry with is_bne=1 and alu_zero=0 raises branch_taken the same way as the BEQ case. If is_branch=1 and is_bne=1 together, the entry is treated as BEQ only.
- When undefined: the port is absent, and only the is_branch/alu_zero=1 condition raises branch_taken.

Test Plan:
- Single pass: reset, then in_valid=1 with alu_result=32'd16, rd_addr=5'd3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_result=16, out_rd_addr=3; following cycle out_valid=0.
- Back-pressure: out_ready=0, accept results 6 then 7 -> in_ready=0 after the second; third offer of 8 is not accepted. Raise out_ready -> outputs 6, then 7, then 8 accepted; ordering preserved.
- Branch taken: is_branch=1, alu_zero=1, branch_pc=32'h0000_0040 -> branch_taken=1 for one cycle with branch_target=32'h40. Same with alu_zero=0 -> branch_taken stays 0.
- Flush while FULL: two held entries, flush=1 with in_valid=1 and is_branch=1, alu_zero=1 -> next cycle out_valid=0, in_ready=1, branch_taken=0.
- Reset mid-stream: FULL state, reset=1 with flush=1 -> all outputs zero, in_ready=1. The first post-reset accept appears with latency 1.
- EX_MEM_BNE_EN: is_bne=1, alu_zero=0, branch_pc=32'h80 -> branch_taken pulse with target 32'h80. With alu_zero=1 -> no pulse.
